bcd_two_digit_counter: RTL and testbench
========================================

Name: bcd_two_digit_counter

Overview:
Two-digit BCD counter that produces the tens/units digit pair consumed by the display path's BCD mux and 7-segment decoders. It has two modes. In RUN mode it advances on an internal prescaled tick. In SET mode the user edits the value with inc/dec pushbuttons. It wraps at a programmable maximum, so one block serves hours (00-23) or minutes/seconds (00-59), and carry_out cascades instances.

Parameters:
MAX_VALUE, 23, highest count before wrap to 00; legal range 1..99.
PRESCALE, 50000000, clk cycles per RUN-mode tick; must be at least 1.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  synchronous, active-high reset.
set_mode  input  1  1 = SET mode, 0 = RUN mode; level, synchronous to clk.
cascade_in  input  1  external tick, one-cycle pulse, e.g. carry_out of a lower-order instance; counted in RUN mode like an internal tick.
inc_btn  input  1  increment request, level (already debounced); rising edge acts.
dec_btn  input  1  decrement request, level; rising edge acts.
load  input  1  one-cycle strobe; loads load_tens/load_unit.
load_tens  input  4  BCD tens digit to load.
load_unit  input  4  BCD units digit to load.
tens_out  output  4  current tens digit, BCD.
unit_out  output  4  current units digit, BCD.
carry_out  output  1  one-cycle pulse on RUN-mode wrap MAX_VALUE→00.
load_err  output  1  one-cycle pulse when a load value is rejected.

Behaviour:
- Reset (reset=1 at a clk edge) has priority over everything:
  - tens_out=0, unit_out=0.
  - carry_out=0, load_err=0.
  - Prescaler count=0.
  - FSM enters RUN.
  - Button edge registers cleared to 0, so a button held through reset does not fire on release of reset.
  - Reset mid-count discards the prescaler phase.
- FSM: two states, RUN and SET. The state register follows set_mode with a one-cycle registration.
  - RUN→SET: prescaler cleared to 0.
  - SET→RUN: prescaler starts from 0, so the first tick comes exactly PRESCALE cycles after entering RUN.
- Prescaler:
  - In RUN it counts 0..PRESCALE-1.
  - Internal tick is asserted in the cycle where count==PRESCALE-1; count then returns to 0.
  - In SET it is held at 0.
- Advance event in RUN = internal tick OR cascade_in. Coincident tick and cascade_in count once.
- Advance:
  - units+1.
  - If units was 9: units=0 and tens+1.
  - If the value equals MAX_VALUE: both digits go to 0 and carry_out=1 in the following cycle (registered, exactly one cycle wide).
- SET mode:
  - Rising edge of inc_btn (registered previous level 0, current 1) adds +1 with the same wrap rule, but carry_out stays 0.
  - Rising edge of dec_btn subtracts 1. At units 0: units=9 and tens-1. At 00: wraps to MAX_VALUE digits. No carry or borrow output.
  - Inc and dec edges in the same cycle cancel; value unchanged.
  - Buttons are ignored in RUN; edge registers still track levels.
  - A held button produces exactly one step.
- Load is valid in either mode and has priority over inc/dec and advance in the same cycle.
  - Accepted iff load_unit≤9, load_tens≤9, and 10·load_tens+load_unit≤MAX_VALUE. New value visible the next cycle.
  - Otherwise the value is unchanged and load_err pulses for one cycle.
  - Load does not reset the prescaler and never generates carry_out.
- Outputs are registered: a value change appears one cycle after the causing event edge. The outputs never hold a non-BCD digit or a value above MAX_VALUE.
- Event priority per cycle: reset > load > (SET: inc/dec | RUN: advance).

Test Plan:
- Reset check: assert reset 2 cycles with inc_btn=1 held, then release. Required: tens/unit=0/0, carry_out=0, load_err=0, and no increment on release.
- RUN wrap (PRESCALE=4, MAX_VALUE=23): load 2/2, run. Required:
  - 2/3 four cycles later, then 0/0 after a further 4 cycles.
  - carry_out high exactly one cycle, aligned with the 0/0 transition.
  - 0/9→1/0 tens rollover verified earlier in the run.
- SET editing: in SET at 0/0, one dec_btn pulse → 2/3. Hold inc_btn 10 cycles → 0/0 (single step, wrap). Inc and dec rising together → unchanged.
- Load validation (MAX_VALUE=59):
  - load 6/0 → value unchanged, load_err one-cycle pulse.
  - load 1/10 → rejected.
  - load 5/9 → 5/9, load_err=0.
  - load coincident with cascade_in → loaded value wins, no extra increment.
- Cascade and mode switch:
  - In RUN, pulse cascade_in in the same cycle as the internal tick → single increment.
  - Toggle to SET mid-prescale, then back to RUN → first tick exactly PRESCALE cycles after set_mode falls (plus the one-cycle registration).
- Reset mid-operation: assert reset while carry_out is due the next cycle → carry_out stays 0, outputs 0/0.

Source files
------------

// File: rtl/bcd_two_digit_counter.sv
// Two-digit BCD counter: RUN mode advances on a prescaled tick or cascade_in,
// SET mode steps with inc/dec button edges; the value wraps at MAX_VALUE.
module bcd_two_digit_counter #(
    parameter int MAX_VALUE = 23,
    parameter int PRESCALE  = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mode,
    input  logic       cascade_in,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_unit,
    output logic [3:0] tens_out,
    output logic [3:0] unit_out,
    output logic       carry_out,
    output logic       load_err
);

    localparam int            PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]    MAX_TENS      = 4'(MAX_VALUE / 10);
    localparam logic [3:0]    MAX_UNIT      = 4'(MAX_VALUE % 10);
    localparam logic [7:0]    MAX_BIN       = 8'(MAX_VALUE);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] prescale_count;
    logic          inc_prev;
    logic          dec_prev;

    logic          tick;
    logic          advance;
    logic          at_max;
    logic          at_zero;
    logic          inc_edge;
    logic          dec_edge;
    logic          load_ok;
    logic [7:0]    load_bin;
    logic [3:0]    inc_tens;
    logic [3:0]    inc_unit;
    logic [3:0]    dec_tens;
    logic [3:0]    dec_unit;

    // Next-value candidates for one step up or down, with wrap at 00 / MAX_VALUE.
    always_comb begin
        tick     = (state == RUN) && (prescale_count == PRESCALE_LAST);
        advance  = (state == RUN) && (tick || cascade_in);
        at_max   = (tens_out == MAX_TENS) && (unit_out == MAX_UNIT);
        at_zero  = (tens_out == 4'd0) && (unit_out == 4'd0);
        inc_edge = inc_btn && !inc_prev;
        dec_edge = dec_btn && !dec_prev;
        load_bin = ({4'd0, load_tens} * 8'd10) + {4'd0, load_unit};
        load_ok  = (load_tens <= 4'd9) && (load_unit <= 4'd9) && (load_bin <= MAX_BIN);

        inc_tens = tens_out;
        inc_unit = unit_out + 4'd1;
        if (at_max) begin
            inc_tens = 4'd0;
            inc_unit = 4'd0;
        end else if (unit_out == 4'd9) begin
            inc_tens = tens_out + 4'd1;
            inc_unit = 4'd0;
        end

        dec_tens = tens_out;
        dec_unit = unit_out - 4'd1;
        if (at_zero) begin
            dec_tens = MAX_TENS;
            dec_unit = MAX_UNIT;
        end else if (unit_out == 4'd0) begin
            dec_tens = tens_out - 4'd1;
            dec_unit = 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            prescale_count <= '0;
            inc_prev       <= 1'b0;
            dec_prev       <= 1'b0;
            tens_out       <= 4'd0;
            unit_out       <= 4'd0;
            carry_out      <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            state     <= set_mode ? SET : RUN;
            inc_prev  <= inc_btn;
            dec_prev  <= dec_btn;
            carry_out <= 1'b0;
            load_err  <= 1'b0;

            // Prescaler only runs in RUN, so re-entering RUN always restarts a full period.
            if ((state == RUN) && !tick) begin
                prescale_count <= prescale_count + PW'(1);
            end else begin
                prescale_count <= '0;
            end

            if (load) begin
                if (load_ok) begin
                    tens_out <= load_tens;
                    unit_out <= load_unit;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (state == SET) begin
                if (inc_edge && !dec_edge) begin
                    tens_out <= inc_tens;
                    unit_out <= inc_unit;
                end else if (dec_edge && !inc_edge) begin
                    tens_out <= dec_tens;
                    unit_out <= dec_unit;
                end
            end else if (advance) begin
                tens_out  <= inc_tens;
                unit_out  <= inc_unit;
                carry_out <= at_max;
            end
        end
    end

endmodule

// File: tb/tb_bcd_two_digit_counter.sv
// Bench for bcd_two_digit_counter: hand sequences on a 00-23 instance and a
// table of directed vectors on a 00-59 instance.
module tb_bcd_two_digit_counter;

    typedef struct {
        string      name;
        logic [4:0] ctl;        // {set_mode, inc, dec, cascade, load}
        logic [3:0] lt;
        logic [3:0] lu;
        logic [3:0] exp_tens;
        logic [3:0] exp_unit;
        logic       exp_carry;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    logic       a_set_mode, a_cascade_in, a_inc_btn, a_dec_btn, a_load;
    logic [3:0] a_load_tens, a_load_unit, a_tens_out, a_unit_out;
    logic       a_carry_out, a_load_err;

    logic       b_set_mode, b_cascade_in, b_inc_btn, b_dec_btn, b_load;
    logic [3:0] b_load_tens, b_load_unit, b_tens_out, b_unit_out;
    logic       b_carry_out, b_load_err;

    int tests_run    = 0;
    int tests_failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bcd_two_digit_counter #(.MAX_VALUE(23), .PRESCALE(4)) dut23 (
        .clk(clk), .reset(reset), .set_mode(a_set_mode), .cascade_in(a_cascade_in),
        .inc_btn(a_inc_btn), .dec_btn(a_dec_btn), .load(a_load),
        .load_tens(a_load_tens), .load_unit(a_load_unit),
        .tens_out(a_tens_out), .unit_out(a_unit_out),
        .carry_out(a_carry_out), .load_err(a_load_err)
    );

    bcd_two_digit_counter #(.MAX_VALUE(59), .PRESCALE(1000)) dut59 (
        .clk(clk), .reset(reset), .set_mode(b_set_mode), .cascade_in(b_cascade_in),
        .inc_btn(b_inc_btn), .dec_btn(b_dec_btn), .load(b_load),
        .load_tens(b_load_tens), .load_unit(b_load_unit),
        .tens_out(b_tens_out), .unit_out(b_unit_out),
        .carry_out(b_carry_out), .load_err(b_load_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name,
                                input logic [3:0] got_t, input logic [3:0] got_u,
                                input logic got_c, input logic got_e,
                                input logic [3:0] exp_t, input logic [3:0] exp_u,
                                input logic exp_c, input logic exp_e);
        tests_run++;
        if ({got_t, got_u, got_c, got_e} !== {exp_t, exp_u, exp_c, exp_e}) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d/%0d carry=%b err=%b, expected %0d/%0d carry=%b err=%b",
                     name, got_t, got_u, got_c, got_e, exp_t, exp_u, exp_c, exp_e);
        end
    endtask

    task automatic check_a(input string name, input logic [3:0] et, input logic [3:0] eu,
                           input logic ec, input logic ee);
        check_output(name, a_tens_out, a_unit_out, a_carry_out, a_load_err, et, eu, ec, ee);
    endtask

    task automatic apply_stimulus(input vec_t v);
        {b_set_mode, b_inc_btn, b_dec_btn, b_cascade_in, b_load} = v.ctl;
        b_load_tens = v.lt;
        b_load_unit = v.lu;
        step();
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] ctl,
                                input logic [3:0] lt, input logic [3:0] lu,
                                input logic [3:0] et, input logic [3:0] eu,
                                input logic ec, input logic ee);
        vec_t v;
        v.name = name; v.ctl = ctl; v.lt = lt; v.lu = lu;
        v.exp_tens = et; v.exp_unit = eu; v.exp_carry = ec; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        // ctl = {set_mode, inc, dec, cascade, load}; dut59 starts at 00 in RUN
        vecs.push_back(mk("load 6/0 rejected",      5'b00001, 4'd6,  4'd0,  4'd0, 4'd0, 1'b0, 1'b1));
        vecs.push_back(mk("load_err one cycle",     5'b00000, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("load 1/10 rejected",     5'b00001, 4'd1,  4'd10, 4'd0, 4'd0, 1'b0, 1'b1));
        vecs.push_back(mk("load 10/0 rejected",     5'b00001, 4'd10, 4'd0,  4'd0, 4'd0, 1'b0, 1'b1));
        vecs.push_back(mk("load 5/9 accepted",      5'b00001, 4'd5,  4'd9,  4'd5, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("load beats cascade",     5'b00011, 4'd3,  4'd4,  4'd3, 4'd4, 1'b0, 1'b0));
        vecs.push_back(mk("cascade step",           5'b00010, 4'd0,  4'd0,  4'd3, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("idle run",               5'b00000, 4'd0,  4'd0,  4'd3, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("load 5/9 again",         5'b00001, 4'd5,  4'd9,  4'd5, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("cascade wrap carry",     5'b00010, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0));
        vecs.push_back(mk("carry one cycle",        5'b00000, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("cascade from 00",        5'b00010, 4'd0,  4'd0,  4'd0, 4'd1, 1'b0, 1'b0));
        vecs.push_back(mk("load 0/9",               5'b00001, 4'd0,  4'd9,  4'd0, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("cascade tens rollover",  5'b00010, 4'd0,  4'd0,  4'd1, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("enter set",              5'b10000, 4'd0,  4'd0,  4'd1, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("set dec borrow",         5'b10100, 4'd0,  4'd0,  4'd0, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("dec held one step",      5'b10100, 4'd0,  4'd0,  4'd0, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("dec release",            5'b10000, 4'd0,  4'd0,  4'd0, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("set inc into tens",      5'b11000, 4'd0,  4'd0,  4'd1, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("inc release",            5'b10000, 4'd0,  4'd0,  4'd1, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("cascade ignored in set", 5'b10010, 4'd0,  4'd0,  4'd1, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("load 0/0 in set",        5'b10001, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("set dec wrap to max",    5'b10100, 4'd0,  4'd0,  4'd5, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("dec release 2",          5'b10000, 4'd0,  4'd0,  4'd5, 4'd9, 1'b0, 1'b0));
        vecs.push_back(mk("set inc wrap no carry",  5'b11000, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("inc release 2",          5'b10000, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0));
        vecs.push_back(mk("load beats inc",         5'b11001, 4'd4,  4'd2,  4'd4, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("inc release 3",          5'b10000, 4'd0,  4'd0,  4'd4, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("load 9/9 rejected set",  5'b10001, 4'd9,  4'd9,  4'd4, 4'd2, 1'b0, 1'b1));
        vecs.push_back(mk("back to run",            5'b00000, 4'd0,  4'd0,  4'd4, 4'd2, 1'b0, 1'b0));
        vecs.push_back(mk("run ignores inc",        5'b01000, 4'd0,  4'd0,  4'd4, 4'd2, 1'b0, 1'b0));

        reset = 1'b1;
        a_set_mode = 1'b0; a_cascade_in = 1'b0; a_inc_btn = 1'b1; a_dec_btn = 1'b0;
        a_load = 1'b0; a_load_tens = 4'd0; a_load_unit = 4'd0;
        b_set_mode = 1'b0; b_cascade_in = 1'b0; b_inc_btn = 1'b0; b_dec_btn = 1'b0;
        b_load = 1'b0; b_load_tens = 4'd0; b_load_unit = 4'd0;

        step();
        step();
        check_a("reset state", 4'd0, 4'd0, 1'b0, 1'b0);
        check_output("reset state b", b_tens_out, b_unit_out, b_carry_out, b_load_err,
                     4'd0, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // One tick every 4 cycles from reset release; k=1 also covers the held inc_btn.
        for (int k = 1; k <= 43; k++) begin
            if (k == 3) a_inc_btn = 1'b0;
            step();
            check_a($sformatf("run count k=%0d", k), 4'((k / 4) / 10), 4'((k / 4) % 10), 1'b0, 1'b0);
        end

        // Load lands on the tick cycle, so the next tick is a full period later.
        a_load = 1'b1; a_load_tens = 4'd2; a_load_unit = 4'd2;
        step();
        a_load = 1'b0;
        check_a("load 2/2", 4'd2, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("hold 2/2", 4'd2, 4'd2, 1'b0, 1'b0);
        end
        step();
        check_a("tick to 2/3", 4'd2, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("hold 2/3", 4'd2, 4'd3, 1'b0, 1'b0);
        end
        step();
        check_a("wrap with carry", 4'd0, 4'd0, 1'b1, 1'b0);
        step();
        check_a("carry drops", 4'd0, 4'd0, 1'b0, 1'b0);
        step();
        step();
        check_a("before tick", 4'd0, 4'd0, 1'b0, 1'b0);

        a_cascade_in = 1'b1;
        step();
        a_cascade_in = 1'b0;
        check_a("cascade with tick once", 4'd0, 4'd1, 1'b0, 1'b0);
        step();
        check_a("after coincident", 4'd0, 4'd1, 1'b0, 1'b0);
        a_cascade_in = 1'b1;
        step();
        a_cascade_in = 1'b0;
        check_a("cascade alone", 4'd0, 4'd2, 1'b0, 1'b0);
        step();
        check_a("after cascade", 4'd0, 4'd2, 1'b0, 1'b0);
        step();
        check_a("tick after cascade", 4'd0, 4'd3, 1'b0, 1'b0);
        step();

        a_set_mode = 1'b1;
        step();
        step();
        step();
        check_a("mid-prescale set", 4'd0, 4'd3, 1'b0, 1'b0);
        a_set_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_a($sformatf("rerun wait %0d", i), 4'd0, 4'd3, 1'b0, 1'b0);
        end
        step();
        check_a("first tick after set", 4'd0, 4'd4, 1'b0, 1'b0);

        a_set_mode = 1'b1; a_load = 1'b1; a_load_tens = 4'd0; a_load_unit = 4'd0;
        step();
        a_load = 1'b0;
        check_a("load 0/0", 4'd0, 4'd0, 1'b0, 1'b0);
        a_dec_btn = 1'b1;
        step();
        a_dec_btn = 1'b0;
        check_a("dec wrap to 2/3", 4'd2, 4'd3, 1'b0, 1'b0);
        step();
        check_a("dec released", 4'd2, 4'd3, 1'b0, 1'b0);
        a_inc_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_a($sformatf("inc held %0d", i), 4'd0, 4'd0, 1'b0, 1'b0);
        end
        a_inc_btn = 1'b0;
        step();
        a_inc_btn = 1'b1; a_dec_btn = 1'b1;
        step();
        check_a("inc dec cancel", 4'd0, 4'd0, 1'b0, 1'b0);
        a_inc_btn = 1'b0; a_dec_btn = 1'b0;
        step();

        a_load = 1'b1; a_load_tens = 4'd2; a_load_unit = 4'd3;
        step();
        a_load = 1'b0;
        a_set_mode = 1'b0;
        check_a("load 2/3 in set", 4'd2, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_a("run toward wrap", 4'd2, 4'd3, 1'b0, 1'b0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_a("reset kills carry", 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("post reset phase", 4'd0, 4'd0, 1'b0, 1'b0);
        end
        step();
        check_a("tick after reset", 4'd0, 4'd1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i].name, b_tens_out, b_unit_out, b_carry_out, b_load_err,
                         vecs[i].exp_tens, vecs[i].exp_unit, vecs[i].exp_carry, vecs[i].exp_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
